// File: rtl/mem_arbiter.sv
// Two-port arbiter for a single-port sync-read data memory: CPU (port 0) and
// UART loader (port 1). BOOT mode serves only the loader; RUN is round-robin.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   boot_done           pulse that moves BOOT -> RUN
//   reqN_valid/ready    request handshake (ready = grant, same cycle)
//   reqN_addr/wdata/we  request payload; we == 0 means read
//   rspN_valid/rdata    read response, one cycle after accept
//   mem_en/we/addr/din  memory request side
//   mem_dout            memory read data (one-cycle latency)
//   mode_run            high in RUN
module mem_arbiter #(
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    boot_done,
   input  logic                    req0_valid,
   output logic                    req0_ready,
   input  logic [ADDR_WIDTH-1:0]   req0_addr,
   input  logic [DATA_WIDTH-1:0]   req0_wdata,
   input  logic [DATA_WIDTH/8-1:0] req0_we,
   input  logic                    req1_valid,
   output logic                    req1_ready,
   input  logic [ADDR_WIDTH-1:0]   req1_addr,
   input  logic [DATA_WIDTH-1:0]   req1_wdata,
   input  logic [DATA_WIDTH/8-1:0] req1_we,
   output logic                    rsp0_valid,
   output logic [DATA_WIDTH-1:0]   rsp0_rdata,
   output logic                    rsp1_valid,
   output logic [DATA_WIDTH-1:0]   rsp1_rdata,
   output logic                    mem_en,
   output logic [DATA_WIDTH/8-1:0] mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_din,
   input  logic [DATA_WIDTH-1:0]   mem_dout,
   output logic                    mode_run
);

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;
   state_t state_eff;

   logic last_grant;
   logic last_grant_nxt;
   logic rd_pending;
   logic rd_pending_nxt;
   logic rd_owner;
   logic rd_owner_nxt;
   logic grant0;
   logic grant1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= BOOT;
         last_grant <= 1'b1;
         rd_pending <= 1'b0;
         rd_owner   <= 1'b0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         rd_pending <= rd_pending_nxt;
         rd_owner   <= rd_owner_nxt;
      end
   end

   // While rst is high the request path behaves as BOOT even before the
   // state register has been cleared by the first reset edge.
   assign state_eff = rst ? BOOT : state;

   always_comb begin
      grant0         = 1'b0;
      grant1         = 1'b0;
      state_nxt      = state;
      last_grant_nxt = last_grant;
      rd_pending_nxt = 1'b0;
      rd_owner_nxt   = rd_owner;
      mem_en         = 1'b0;
      mem_we         = '0;
      mem_addr       = req0_addr;
      mem_din        = req0_wdata;

      if (state_eff == BOOT) begin
         grant1 = req1_valid;
      end else if (req0_valid && req1_valid) begin
         // tie goes to whichever port was not served last
         grant0 = last_grant;
         grant1 = ~last_grant;
      end else begin
         grant0 = req0_valid;
         grant1 = req1_valid;
      end

      if (state == BOOT && boot_done)
         state_nxt = RUN;

      if (grant0)
         last_grant_nxt = 1'b0;
      else if (grant1)
         last_grant_nxt = 1'b1;

      mem_en = grant0 | grant1;
      if (grant1) begin
         mem_we   = req1_we;
         mem_addr = req1_addr;
         mem_din  = req1_wdata;
      end else if (grant0) begin
         mem_we   = req0_we;
      end

      if (mem_en && (mem_we == '0)) begin
         rd_pending_nxt = 1'b1;
         rd_owner_nxt   = grant1;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // a read accepted just before reset must not surface during reset
   assign rsp0_valid = rd_pending & ~rst & ~rd_owner;
   assign rsp1_valid = rd_pending & ~rst & rd_owner;
   assign rsp0_rdata = mem_dout;
   assign rsp1_rdata = mem_dout;

   assign mode_run = (state_eff == RUN);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level model with a shadow memory.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        boot_done;
   logic        r0v, r1v;
   logic [13:0] r0a, r1a;
   logic [31:0] r0d, r1d;
   logic [3:0]  r0w, r1w;
   logic        req0_ready, req1_ready;
   logic        rsp0_valid, rsp1_valid;
   logic [31:0] rsp0_rdata, rsp1_rdata;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [13:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;
   logic        mode_run;

   logic [31:0] mem    [16384];
   logic [31:0] shadow [16384];

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: mode, who wins a tie, outstanding read
   bit          run  = 0;
   bit          tie0 = 1;
   bit          pend = 0;
   bit          pown = 0;
   logic [31:0] pdata;
   bit          g0, g1;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .boot_done  (boot_done),
      .req0_valid (r0v),
      .req0_ready (req0_ready),
      .req0_addr  (r0a),
      .req0_wdata (r0d),
      .req0_we    (r0w),
      .req1_valid (r1v),
      .req1_ready (req1_ready),
      .req1_addr  (r1a),
      .req1_wdata (r1d),
      .req1_we    (r1w),
      .rsp0_valid (rsp0_valid),
      .rsp0_rdata (rsp0_rdata),
      .rsp1_valid (rsp1_valid),
      .rsp1_rdata (rsp1_rdata),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .mem_dout   (mem_dout),
      .mode_run   (mode_run)
   );

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we == 4'h0)
            mem_dout <= mem[mem_addr];
         else
            for (int b = 0; b < 4; b++)
               if (mem_we[b])
                  mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      bit          e0, e1, rv;
      logic [3:0]  ew;
      logic [13:0] ea;
      logic [31:0] ed;
      @(negedge clk);
      if (rst || !run) begin
         e0 = 0;
         e1 = r1v;
      end else if (r0v && r1v) begin
         e0 = tie0;
         e1 = !tie0;
      end else begin
         e0 = r0v;
         e1 = r1v;
      end
      ea = e1 ? r1a : r0a;
      ed = e1 ? r1d : r0d;
      ew = e1 ? r1w : (e0 ? r0w : 4'h0);
      rv = pend && !rst;
      check("ready0", {31'b0, req0_ready}, {31'b0, e0});
      check("ready1", {31'b0, req1_ready}, {31'b0, e1});
      check("mem_en", {31'b0, mem_en}, {31'b0, e0 | e1});
      check("mem_addr", {18'b0, mem_addr}, {18'b0, ea});
      check("mem_din", mem_din, ed);
      check("mem_we", {28'b0, mem_we}, {28'b0, ew});
      check("mode_run", {31'b0, mode_run}, {31'b0, run && !rst});
      check("rsp0_valid", {31'b0, rsp0_valid}, {31'b0, rv && !pown});
      check("rsp1_valid", {31'b0, rsp1_valid}, {31'b0, rv && pown});
      if (rv) begin
         check("rsp0_rdata", rsp0_rdata, pdata);
         check("rsp1_rdata", rsp1_rdata, pdata);
      end
      g0 = e0;
      g1 = e1;
      @(posedge clk);
      pend = 0;
      if (e0 || e1) begin
         if (ew == 4'h0) begin
            pend  = 1;
            pown  = e1;
            pdata = shadow[ea];
         end else begin
            for (int b = 0; b < 4; b++)
               if (ew[b])
                  shadow[ea][8*b +: 8] = ed[8*b +: 8];
         end
      end
      if (rst) begin
         run  = 0;
         tie0 = 1;
         pend = 0;
      end else begin
         if (boot_done)
            run = 1;
         if (e0)
            tie0 = 0;
         else if (e1)
            tie0 = 1;
      end
      #1;
   endtask

   task automatic retire();
      if (g0) r0v = 0;
      if (g1) r1v = 0;
   endtask

   task automatic preload(input logic [13:0] a, input logic [31:0] d);
      mem[a]    = d;
      shadow[a] = d;
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) begin
         mem[i]    = 32'h0;
         shadow[i] = 32'h0;
      end
      rst = 1; boot_done = 0;
      r0v = 0; r0a = 0; r0d = 0; r0w = 0;
      r1v = 0; r1a = 0; r1d = 0; r1w = 0;
      tick();
      tick();
      rst = 0;

      // BOOT: CPU port is locked out
      r0v = 1; r0a = 14'h10;
      repeat (5) tick();
      r0v = 0;

      // BOOT: loader writes then reads back
      r1v = 1; r1a = 14'h20; r1d = 32'hDEADBEEF; r1w = 4'hF;
      tick();
      r1w = 4'h0;
      tick();
      r1v = 0;
      tick();
      check("boot_rd_data", rsp1_rdata, 32'hDEADBEEF);

      // boot_done with both requesting, then 8 contended cycles
      r0v = 1; r0a = 14'h1; r0w = 0;
      r1v = 1; r1a = 14'h2; r1w = 0;
      boot_done = 1;
      tick();
      boot_done = 0;
      repeat (8) tick();
      r0v = 0; r1v = 0;
      tick();

      // contended reads return in order to the right owner
      preload(14'h04, 32'h11111111);
      preload(14'h08, 32'h22222222);
      r0v = 1; r0a = 14'h04;
      r1v = 1; r1a = 14'h08;
      tick(); retire();
      tick(); retire();
      tick();
      tick();

      // byte write then read back
      preload(14'h30, 32'h12345678);
      r0v = 1; r0a = 14'h30; r0d = 32'h0000AB00; r0w = 4'h2;
      tick();
      r0w = 4'h0;
      tick();
      r0v = 0;
      tick();
      check("byte_merge_mem", mem[14'h30], 32'h1234AB78);

      // reset right after a read accept drops the response
      r0v = 1; r0a = 14'h04;
      tick();
      r0v = 0; rst = 1;
      tick();
      rst = 0;
      tick();
      r0v = 1;
      tick();
      tick();
      boot_done = 1;
      tick();
      boot_done = 0;
      r1v = 1;
      tick(); retire();
      tick(); retire();
      tick();

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         if (!r0v) begin
            r0v = 1'($urandom % 2);
            r0a = 14'($urandom % 16);
            r0d = $urandom;
            r0w = ($urandom % 2) ? 4'h0 : 4'($urandom % 16);
         end
         if (!r1v) begin
            r1v = 1'($urandom % 2);
            r1a = 14'($urandom % 16);
            r1d = $urandom;
            r1w = ($urandom % 2) ? 4'h0 : 4'($urandom % 16);
         end
         rst       = ($urandom % 50) == 0;
         boot_done = ($urandom % 12) == 0;
         tick();
         retire();
      end
      rst = 0; boot_done = 0; r0v = 0; r1v = 0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
